// File: rtl/if_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package if_pkg;

    localparam int PC_W = 64;

    // Architectural NOP; decode maps it to its default no-write controls.
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface if_fetch_stage_if #(
    parameter int PC_W = if_pkg::PC_W
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module ifid_reg
    import if_pkg::*;
#(
    parameter int PC_W = if_pkg::PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     load_instr,
    input  logic [PC_W-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;

    // Next IF/ID contents; a bubble keeps the old pc so debug views stay stable.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    // Register with synchronous reset to an empty NOP slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one memory request in flight, parks a
// response in a hold buffer while decode is stalled, and discards responses
// that a redirect has made stale.
//
//   state | meaning
//   ISSUE | request for pc goes out this cycle (unless redirected)
//   WAIT  | request outstanding, waiting for rvalid
//   HOLD  | response captured in hold buffer, waiting for stall to drop
//   DROP  | request outstanding but redirected; its response is thrown away
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int              PC_W     = if_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    if_fetch_stage_if.master         imem,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     ifid_valid,
    output logic [31:0]              ifid_instr,
    output logic [PC_W-1:0]          ifid_pc
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     buf_q, buf_d;

    logic            ifid_load;
    logic [31:0]     ifid_load_instr;
    logic [PC_W-1:0] redir_pc;
    logic [PC_W-1:0] pc_next_seq;

    assign redir_pc    = {redirect_pc[PC_W-1:2], 2'b00};
    assign pc_next_seq = pc_q + PC_W'(4);

    assign imem.req  = (state_q == ISSUE) && !redirect && !reset;
    assign imem.addr = pc_q;

    // Fetch FSM next state, PC update, hold buffer capture and IF/ID load request.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        buf_d           = buf_q;
        ifid_load       = 1'b0;
        ifid_load_instr = imem.rdata;
        case (state_q)
            ISSUE: begin
                if (redirect) begin
                    pc_d = redir_pc;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    state_d = imem.rvalid ? ISSUE : DROP;
                end else if (imem.rvalid) begin
                    if (stall) begin
                        buf_d   = imem.rdata;
                        state_d = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_next_seq;
                        state_d   = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_d   = NOP_INSTR;
                    pc_d    = redir_pc;
                    state_d = ISSUE;
                end else if (!stall) begin
                    ifid_load       = 1'b1;
                    ifid_load_instr = buf_q;
                    pc_d            = pc_next_seq;
                    state_d         = ISSUE;
                end
            end
            DROP: begin
                // Latest redirect wins even while the stale response is pending.
                if (redirect) begin
                    pc_d = redir_pc;
                end
                if (imem.rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // State, PC and hold buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // The PC still equals the fetched address in WAIT/HOLD, so it tags the load.
    ifid_reg #(.PC_W(PC_W)) u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .stall      (stall),
        .flush      (redirect),
        .load_instr (ifid_load_instr),
        .load_pc    (pc_q),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a simple latency-configurable memory.
module tb_if_fetch_stage;
    import if_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: RESET_PC = 0, full stimulus.
    logic        stall_a, redirect_a;
    logic [63:0] redirect_pc_a;
    logic        ifid_valid_a;
    logic [31:0] ifid_instr_a;
    logic [63:0] ifid_pc_a;
    if_fetch_stage_if #(.PC_W(64)) mif_a ();

    if_fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut_a (
        .clk(clk), .reset(reset), .imem(mif_a.master),
        .stall(stall_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .ifid_valid(ifid_valid_a), .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a)
    );

    // Instance B: RESET_PC just below the wrap point.
    logic        stall_b, redirect_b;
    logic [63:0] redirect_pc_b;
    logic        ifid_valid_b;
    logic [31:0] ifid_instr_b;
    logic [63:0] ifid_pc_b;
    if_fetch_stage_if #(.PC_W(64)) mif_b ();

    if_fetch_stage #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .imem(mif_b.master),
        .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .ifid_valid(ifid_valid_b), .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd8) return 32'h91000421;
        return 32'hE000_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory A: response appears lat_a cycles after the request cycle.
    int          lat_a = 1;
    int          cnt_a;
    logic [63:0] maddr_a;
    always @(posedge clk) begin
        if (reset) begin
            cnt_a        <= 0;
            mif_a.rvalid <= 1'b0;
            mif_a.rdata  <= 32'h0;
        end else begin
            mif_a.rvalid <= 1'b0;
            if (cnt_a != 0) begin
                if (cnt_a == 1) begin
                    mif_a.rvalid <= 1'b1;
                    mif_a.rdata  <= mem_word(maddr_a);
                end
                cnt_a <= cnt_a - 1;
            end else if (mif_a.req) begin
                if (lat_a == 1) begin
                    mif_a.rvalid <= 1'b1;
                    mif_a.rdata  <= mem_word(mif_a.addr);
                end else begin
                    cnt_a   <= lat_a - 1;
                    maddr_a <= mif_a.addr;
                end
            end
        end
    end

    // Memory B: fixed latency 1.
    always @(posedge clk) begin
        if (reset) begin
            mif_b.rvalid <= 1'b0;
            mif_b.rdata  <= 32'h0;
        end else begin
            mif_b.rvalid <= mif_b.req;
            if (mif_b.req) mif_b.rdata <= mem_word(mif_b.addr);
        end
    end

    // A response must only arrive while a request is outstanding.
    always @(posedge clk) begin
        if (!reset && mif_a.rvalid)
            assert (dut_a.state_q == WAIT || dut_a.state_q == DROP)
                else $error("protocol: rvalid outside WAIT/DROP");
    end

    task automatic test_reset();
        reset = 1'b1;
        stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = '0;
        stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b0 || ifid_instr_a !== NOP_INSTR || ifid_pc_a !== 64'h0) begin
            errors++;
            $display("FAIL reset_ifid: got v=%0b i=%h pc=%h want v=0 i=%h pc=0",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, NOP_INSTR);
        end
        checks++;
        if (mif_a.req !== 1'b0 || dut_a.state_q !== ISSUE) begin
            errors++;
            $display("FAIL reset_req: got req=%0b state=%0d want req=0 state=ISSUE",
                     mif_a.req, dut_a.state_q);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mif_a.req !== 1'b1 || mif_a.addr !== 64'h0) begin
            errors++;
            $display("FAIL first_fetch: got req=%0b addr=%h want req=1 addr=0", mif_a.req, mif_a.addr);
        end
        checks++;
        if (mif_b.req !== 1'b1 || mif_b.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: got req=%0b addr=%h want req=1 addr=fffffffffffffffc",
                     mif_b.req, mif_b.addr);
        end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        checks++;
        if (mif_a.req !== 1'b0 || ifid_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle: got req=%0b v=%0b want req=0 v=0", mif_a.req, ifid_valid_a);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'hE000_0000 || ifid_pc_a !== 64'h0 ||
            mif_a.req !== 1'b1 || mif_a.addr !== 64'h4) begin
            errors++;
            $display("FAIL seq0: got v=%0b i=%h pc=%h req=%0b addr=%h want v=1 i=e0000000 pc=0 req=1 addr=4",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, mif_a.req, mif_a.addr);
        end
        checks++;
        if (ifid_valid_b !== 1'b1 || ifid_pc_b !== 64'hFFFF_FFFF_FFFF_FFFC ||
            mif_b.req !== 1'b1 || mif_b.addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap_second: got v=%0b pc=%h req=%0b addr=%h want v=1 pc=fffffffffffffffc req=1 addr=0",
                     ifid_valid_b, ifid_pc_b, mif_b.req, mif_b.addr);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b0 || ifid_instr_a !== NOP_INSTR) begin
            errors++;
            $display("FAIL seq_bubble: got v=%0b i=%h want v=0 i=%h", ifid_valid_a, ifid_instr_a, NOP_INSTR);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'hE000_0004 || ifid_pc_a !== 64'h4 ||
            mif_a.addr !== 64'h8 || mif_a.req !== 1'b1) begin
            errors++;
            $display("FAIL seq4: got v=%0b i=%h pc=%h req=%0b addr=%h want v=1 i=e0000004 pc=4 req=1 addr=8",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, mif_a.req, mif_a.addr);
        end
    endtask

    task automatic test_stall();
        stall_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_a.state_q !== HOLD || mif_a.req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got state=%0d req=%0b want state=HOLD req=0", dut_a.state_q, mif_a.req);
        end
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'hE000_0004 || ifid_pc_a !== 64'h4) begin
            errors++;
            $display("FAIL stall_keep: got v=%0b i=%h pc=%h want v=1 i=e0000004 pc=4",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a);
        end
        stall_a = 1'b0;
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'h91000421 || ifid_pc_a !== 64'h8 ||
            mif_a.req !== 1'b1 || mif_a.addr !== 64'hC) begin
            errors++;
            $display("FAIL stall_release: got v=%0b i=%h pc=%h req=%0b addr=%h want v=1 i=91000421 pc=8 req=1 addr=c",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, mif_a.req, mif_a.addr);
        end
    endtask

    task automatic test_redirect_wait();
        lat_a = 2;
        @(negedge clk);
        redirect_a = 1'b1;
        redirect_pc_a = 64'h40;
        @(negedge clk);
        checks++;
        if (dut_a.state_q !== DROP || mif_a.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL redir_drop: got state=%0d rvalid=%0b want state=DROP rvalid=1",
                     dut_a.state_q, mif_a.rvalid);
        end
        redirect_a = 1'b0;
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b0 || ifid_instr_a !== NOP_INSTR || ifid_pc_a !== 64'h8 ||
            mif_a.req !== 1'b1 || mif_a.addr !== 64'h40) begin
            errors++;
            $display("FAIL redir_discard: got v=%0b i=%h pc=%h req=%0b addr=%h want v=0 i=%h pc=8 req=1 addr=40",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, mif_a.req, mif_a.addr, NOP_INSTR);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'hE000_0040 || ifid_pc_a !== 64'h40 ||
            mif_a.addr !== 64'h44) begin
            errors++;
            $display("FAIL redir_fetch: got v=%0b i=%h pc=%h addr=%h want v=1 i=e0000040 pc=40 addr=44",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a, mif_a.addr);
        end
        lat_a = 1;
    endtask

    task automatic test_redirect_stall();
        redirect_a = 1'b1;
        stall_a = 1'b1;
        redirect_pc_a = 64'h80;
        #1;
        checks++;
        if (mif_a.req !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_mask: got req=%0b want 0", mif_a.req);
        end
        @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b0 || ifid_instr_a !== NOP_INSTR || dut_a.pc_q !== 64'h80) begin
            errors++;
            $display("FAIL redir_stall_flush: got v=%0b i=%h pc=%h want v=0 i=%h pc=80",
                     ifid_valid_a, ifid_instr_a, dut_a.pc_q, NOP_INSTR);
        end
        redirect_a = 1'b0;
        stall_a = 1'b0;
        #1;
        checks++;
        if (mif_a.req !== 1'b1 || mif_a.addr !== 64'h80) begin
            errors++;
            $display("FAIL redir_stall_fetch: got req=%0b addr=%h want req=1 addr=80", mif_a.req, mif_a.addr);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        redirect_a = 1'b1;
        redirect_pc_a = 64'h103;
        @(negedge clk);
        redirect_a = 1'b0;
        #1;
        checks++;
        if (mif_a.req !== 1'b1 || mif_a.addr !== 64'h100 || ifid_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: got req=%0b addr=%h v=%0b want req=1 addr=100 v=0",
                     mif_a.req, mif_a.addr, ifid_valid_a);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ifid_valid_a !== 1'b1 || ifid_instr_a !== 32'hE000_0100 || ifid_pc_a !== 64'h100) begin
            errors++;
            $display("FAIL misaligned_load: got v=%0b i=%h pc=%h want v=1 i=e0000100 pc=100",
                     ifid_valid_a, ifid_instr_a, ifid_pc_a);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
